// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with fill count, watermarks, FWFT option and error pulses
// ports: clk, rst (sync, active-high), push/din, pop/dout, fifo_empty, fifo_full, almost_full,
//        almost_empty, count, overflow, underflow; err_clr/err_sticky when SYNC_FIFO_PROG_STICKY_ERR_EN
module sync_fifo_prog #(
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] din,
  input  logic              pop,
  output logic [DWIDTH-1:0] dout,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
  ,
  input  logic              err_clr,
  output logic [1:0]        err_sticky
`endif
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_prog: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("sync_fifo_prog: AF_THRESH out of range");
  end
  if (AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_prog: AE_THRESH out of range");
  end
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              pop_ok, push_ok;
  assign count        = wr_ptr - rd_ptr;
  assign fifo_full    = count == DEPTH_C;
  assign fifo_empty   = count == '0;
  assign almost_full  = count >= AF_C;
  assign almost_empty = count <= AE_C;
  assign pop_ok       = pop & ~fifo_empty;
  // a pop frees a slot in the same cycle, so a full FIFO still takes the push
  assign push_ok      = push & (~fifo_full | pop_ok);
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + (AW+1)'(push_ok);
      rd_ptr    <= rd_ptr + (AW+1)'(pop_ok);
      overflow  <= push & ~push_ok;
      underflow <= pop & ~pop_ok;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end
  if (FWFT != 0) begin : g_fwft
    assign dout = mem[rd_ptr[AW-1:0]];
  end else begin : g_std
    logic [DWIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (rst) dout_q <= '0;
      else if (pop_ok) dout_q <= mem[rd_ptr[AW-1:0]];
    end
    assign dout = dout_q;
  end
`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
  // a pulse arriving in the clear cycle must survive the clear
  always_ff @(posedge clk) begin
    if (rst) err_sticky <= 2'b00;
    else err_sticky <= {overflow, underflow} | (err_clr ? 2'b00 : err_sticky);
  end
`endif
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: randomized + directed check of sync_fifo_prog (standard and FWFT) against a queue model
module tb_sync_fifo_prog;
  logic       clk = 1'b0, rst = 1'b1, push = 1'b0, pop = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout0, dout1;
  logic       e0, f0, af0, ae0, ov0, un0;
  logic       e1, f1, af1, ae1, ov1, un1;
  logic [2:0] c0, c1;
  logic [7:0] q[$];
  logic [7:0] dm;
  logic       ovm, unm;
  int         vectors = 0, errs = 0;
`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
  logic       clr = 1'b0;
  logic [1:0] st0, st1, stm;
`endif
  always #5 clk = ~clk;
  sync_fifo_prog #(.DWIDTH(8), .FIFO_DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) dut0 (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop), .dout(dout0),
    .fifo_empty(e0), .fifo_full(f0), .almost_full(af0), .almost_empty(ae0),
    .count(c0), .overflow(ov0), .underflow(un0)
`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
    , .err_clr(clr), .err_sticky(st0)
`endif
  );
  sync_fifo_prog #(.DWIDTH(8), .FIFO_DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) dut1 (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop), .dout(dout1),
    .fifo_empty(e1), .fifo_full(f1), .almost_full(af1), .almost_empty(ae1),
    .count(c1), .overflow(ov1), .underflow(un1)
`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
    , .err_clr(clr), .err_sticky(st1)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    int n;
    n = q.size();
    chk("count", 32'(c0), 32'(n));
    chk("empty", 32'(e0), 32'(n == 0));
    chk("full", 32'(f0), 32'(n == 4));
    chk("almost_full", 32'(af0), 32'(n >= 3));
    chk("almost_empty", 32'(ae0), 32'(n <= 1));
    chk("overflow", 32'(ov0), 32'(ovm));
    chk("underflow", 32'(un0), 32'(unm));
    chk("dout", 32'(dout0), 32'(dm));
    chk("fwft_count", 32'(c1), 32'(n));
    chk("fwft_empty", 32'(e1), 32'(n == 0));
    chk("fwft_flags", 32'({f1, af1, ae1, ov1, un1}), 32'({n == 4, n >= 3, n <= 1, ovm, unm}));
    if (n > 0) chk("fwft_dout", 32'(dout1), 32'(q[0]));
`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
    chk("sticky", 32'(st0), 32'(stm));
    chk("fwft_sticky", 32'(st1), 32'(stm));
`endif
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    dm = 8'h00;
    ovm = 1'b0;
    unm = 1'b0;
`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
    stm = 2'b00;
`endif
    check_all();
  endtask
  task automatic cyc(input logic p, input logic o, input logic [7:0] d);
    logic pok, wok;
    push = p;
    pop = o;
    din = d;
    pok = o && q.size() > 0;
    wok = p && (q.size() < 4 || pok);
    @(posedge clk);
    #1;
`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
    stm = {ovm, unm} | (clr ? 2'b00 : stm);
`endif
    if (pok) dm = q.pop_front();
    if (wok) q.push_back(d);
    ovm = p && !wok;
    unm = o && !pok;
    push = 1'b0;
    pop = 1'b0;
    check_all();
  endtask
  initial begin
    do_reset(1);
    cyc(1, 0, 8'h01);
    cyc(1, 0, 8'h02);
    do_reset(2);
    cyc(1, 0, 8'h11);
    cyc(1, 0, 8'h22);
    cyc(1, 0, 8'h33);
    cyc(1, 0, 8'h44);
    cyc(1, 0, 8'h55);
    cyc(0, 0, 8'h00);
    cyc(1, 1, 8'h55);
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);
    cyc(1, 1, 8'hAA);
    cyc(0, 1, 8'h00);
    cyc(1, 0, 8'hA5);
    cyc(0, 0, 8'h00);
    cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);
`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
    do_reset(1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(i));
    for (int i = 0; i < 10; i++) cyc(0, 0, 8'h00);
    clr = 1'b1;
    cyc(0, 0, 8'h00);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    clr = 1'b1;
    cyc(0, 0, 8'h00);
    clr = 1'b0;
    cyc(0, 0, 8'h00);
`endif
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 50) % 3;
      cyc(1'($urandom_range(0, 3) < (bias == 0 ? 3 : 1)),
          1'($urandom_range(0, 3) < (bias == 1 ? 3 : (bias == 0 ? 1 : 2))),
          8'($urandom));
`ifdef SYNC_FIFO_PROG_STICKY_ERR_EN
      clr = 1'($urandom_range(0, 7) == 0);
`endif
      if (i == 300) do_reset(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
